// File: rtl/wb_arbiter_if.sv
// ---------------------------------------------------------------------------
// wb_arbiter_if
// Bundles the write-back arbiter's source, register-file and status signals.
//   ex_*      : execute-stage result (single cycle, never stalled)
//   lsu_*     : load result offer / accept handshake
//   mdu_*     : multiply/divide result offer / accept handshake
//   rd_*, wen : register-file write port
//   pend_mask : destinations currently queued in the FIFO
//   fifo_cnt  : FIFO occupancy
// Modports: slave = arbiter side, master = pipeline / testbench side.
// ---------------------------------------------------------------------------
interface wb_arbiter_if #(
  parameter int DEPTH = 4
) ();
  localparam int PTR_W = $clog2(DEPTH);

  logic             ex_wen;
  logic [4:0]       ex_waddr;
  logic [31:0]      ex_wdata;
  logic             lsu_valid;
  logic             lsu_ready;
  logic [4:0]       lsu_waddr;
  logic [31:0]      lsu_wdata;
  logic             mdu_valid;
  logic             mdu_ready;
  logic [4:0]       mdu_waddr;
  logic [31:0]      mdu_wdata;
  logic [4:0]       rd_waddr;
  logic [31:0]      rd_wdata;
  logic             wen;
  logic [31:0]      pend_mask;
  logic [PTR_W:0]   fifo_cnt;

  modport slave (
    input  ex_wen, ex_waddr, ex_wdata,
    input  lsu_valid, lsu_waddr, lsu_wdata,
    input  mdu_valid, mdu_waddr, mdu_wdata,
    output lsu_ready, mdu_ready,
    output rd_waddr, rd_wdata, wen,
    output pend_mask, fifo_cnt
  );

  modport master (
    output ex_wen, ex_waddr, ex_wdata,
    output lsu_valid, lsu_waddr, lsu_wdata,
    output mdu_valid, mdu_waddr, mdu_wdata,
    input  lsu_ready, mdu_ready,
    input  rd_waddr, rd_wdata, wen,
    input  pend_mask, fifo_cnt
  );
endinterface

// File: rtl/wb_arbiter.sv
// ---------------------------------------------------------------------------
// wb_arbiter
// Owns the single register-file write port. Execute results go straight to
// the registered output stage; LSU and MDU results are queued in a DEPTH-entry
// FIFO and drained whenever execute has no write that cycle.
// Ports:
//   clk  : clock, all state on rising edge
//   rst  : synchronous active-high reset, discards queued results
//   bus  : wb_arbiter_if.slave (sources, register-file port, status)
// Optional build macro:
//   WB_KILL_EN : an execute write to xn invalidates queued entries for xn,
//                which are then popped without writing (keeps WAW order).
// ---------------------------------------------------------------------------
module wb_arbiter #(
  parameter int DEPTH = 4
) (
  input  logic         clk,
  input  logic         rst,
  wb_arbiter_if.slave  bus
);
  localparam int PTR_W = $clog2(DEPTH);
  localparam logic [PTR_W:0] DEPTH_C = (PTR_W+1)'(DEPTH);

  // FIFO storage and pointers
  logic [4:0]       ent_waddr_q [DEPTH];
  logic [31:0]      ent_wdata_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q;
  logic [PTR_W-1:0] rd_ptr_q;
  logic [PTR_W:0]   cnt_q;
`ifdef WB_KILL_EN
  logic [DEPTH-1:0] ent_kill_q;
  logic [DEPTH-1:0] kill_hit_s;
`endif

  // Output stage
  logic             wen_q,      wen_d;
  logic [4:0]       rd_waddr_q, rd_waddr_d;
  logic [31:0]      rd_wdata_q, rd_wdata_d;

  // Control
  logic             ex_act_s;
  logic             pop_s;
  logic             head_live_s;
  logic             lsu_ready_s;
  logic             mdu_ready_s;
  logic             push_s;
  logic [4:0]       push_waddr_s;
  logic [31:0]      push_wdata_s;
  logic [DEPTH-1:0] occ_s;
  logic [31:0]      pend_mask_s;

  // Occupied-slot decode: slot i holds data when its distance from the
  // read pointer is below the occupancy count.
  always_comb begin
    occ_s = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if ({1'b0, PTR_W'(i) - rd_ptr_q} < cnt_q) begin
        occ_s[i] = 1'b1;
      end else begin
        occ_s[i] = 1'b0;
      end
    end
  end

  // Arbitration and push/pop decisions.
  always_comb begin
    // x0 from execute is a non-write, leaving the slot free for a pop.
    ex_act_s    = bus.ex_wen && (bus.ex_waddr != 5'd0);
    pop_s       = !ex_act_s && (cnt_q != '0);
    lsu_ready_s = !rst && ((cnt_q < DEPTH_C) || pop_s);
    mdu_ready_s = lsu_ready_s && !bus.lsu_valid;
    push_s       = 1'b0;
    push_waddr_s = 5'd0;
    push_wdata_s = 32'd0;
    // x0 handshakes complete but store nothing.
    if (bus.lsu_valid && lsu_ready_s && (bus.lsu_waddr != 5'd0)) begin
      push_s       = 1'b1;
      push_waddr_s = bus.lsu_waddr;
      push_wdata_s = bus.lsu_wdata;
    end else if (bus.mdu_valid && mdu_ready_s && (bus.mdu_waddr != 5'd0)) begin
      push_s       = 1'b1;
      push_waddr_s = bus.mdu_waddr;
      push_wdata_s = bus.mdu_wdata;
    end else begin
      push_s       = 1'b0;
    end
  end

`ifdef WB_KILL_EN
  // Entries matching an accepted execute destination are invalidated.
  always_comb begin
    kill_hit_s = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (ex_act_s && occ_s[i] && (ent_waddr_q[i] == bus.ex_waddr)) begin
        kill_hit_s[i] = 1'b1;
      end else begin
        kill_hit_s[i] = 1'b0;
      end
    end
  end
`endif

  // Head liveness and pending-destination mask.
  always_comb begin
`ifdef WB_KILL_EN
    head_live_s = !ent_kill_q[rd_ptr_q];
`else
    head_live_s = 1'b1;
`endif
    pend_mask_s = 32'd0;
    for (int i = 0; i < DEPTH; i++) begin
`ifdef WB_KILL_EN
      if (occ_s[i] && !ent_kill_q[i]) begin
`else
      if (occ_s[i]) begin
`endif
        pend_mask_s = pend_mask_s | (32'd1 << ent_waddr_q[i]);
      end else begin
        pend_mask_s = pend_mask_s;
      end
    end
  end

  // Next value of the output stage.
  always_comb begin
    wen_d      = 1'b0;
    rd_waddr_d = rd_waddr_q;
    rd_wdata_d = rd_wdata_q;
    if (ex_act_s) begin
      wen_d      = 1'b1;
      rd_waddr_d = bus.ex_waddr;
      rd_wdata_d = bus.ex_wdata;
    end else if (pop_s) begin
      // A killed head still pops but produces no write.
      wen_d      = head_live_s;
      rd_waddr_d = ent_waddr_q[rd_ptr_q];
      rd_wdata_d = ent_wdata_q[rd_ptr_q];
    end else begin
      wen_d      = 1'b0;
    end
  end

  // State update: FIFO, pointers, occupancy and output stage.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      cnt_q      <= '0;
      wen_q      <= 1'b0;
      rd_waddr_q <= 5'd0;
      rd_wdata_q <= 32'd0;
      for (int i = 0; i < DEPTH; i++) begin
        ent_waddr_q[i] <= 5'd0;
        ent_wdata_q[i] <= 32'd0;
      end
`ifdef WB_KILL_EN
      ent_kill_q <= '0;
`endif
    end else begin
      wen_q      <= wen_d;
      rd_waddr_q <= rd_waddr_d;
      rd_wdata_q <= rd_wdata_d;
`ifdef WB_KILL_EN
      ent_kill_q <= ent_kill_q | kill_hit_s;
`endif
      if (push_s) begin
        ent_waddr_q[wr_ptr_q] <= push_waddr_s;
        ent_wdata_q[wr_ptr_q] <= push_wdata_s;
        wr_ptr_q              <= wr_ptr_q + PTR_W'(1);
`ifdef WB_KILL_EN
        // A push never coincides with a kill of its own slot: a full-FIFO
        // push needs a pop, which excludes an execute write.
        ent_kill_q[wr_ptr_q]  <= 1'b0;
`endif
      end else begin
        wr_ptr_q <= wr_ptr_q;
      end
      if (pop_s) begin
        rd_ptr_q <= rd_ptr_q + PTR_W'(1);
      end else begin
        rd_ptr_q <= rd_ptr_q;
      end
      case ({push_s, pop_s})
        2'b10:   cnt_q <= cnt_q + (PTR_W+1)'(1);
        2'b01:   cnt_q <= cnt_q - (PTR_W+1)'(1);
        default: cnt_q <= cnt_q;
      endcase
    end
  end

  assign bus.lsu_ready = lsu_ready_s;
  assign bus.mdu_ready = mdu_ready_s;
  assign bus.wen       = wen_q;
  assign bus.rd_waddr  = rd_waddr_q;
  assign bus.rd_wdata  = rd_wdata_q;
  assign bus.pend_mask = pend_mask_s;
  assign bus.fifo_cnt  = cnt_q;

endmodule

// File: tb/tb_wb_arbiter.sv
// ---------------------------------------------------------------------------
// tb_wb_arbiter
// Directed test of wb_arbiter (DEPTH=4): execute path, deferred load,
// fill/full/drain, LSU/MDU priority, x0 results, reset mid-drain and, when
// WB_KILL_EN is defined, killing a queued entry.
// ---------------------------------------------------------------------------
module tb_wb_arbiter;
  logic clk;
  logic rst;
  int   checks;
  int   errors;

  wb_arbiter_if #(.DEPTH(4)) bus ();

  wb_arbiter #(.DEPTH(4)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Advance one clock; outputs are sampled 1 time unit after the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    bus.ex_wen    = 1'b0;
    bus.ex_waddr  = 5'd0;
    bus.ex_wdata  = 32'd0;
    bus.lsu_valid = 1'b0;
    bus.lsu_waddr = 5'd0;
    bus.lsu_wdata = 32'd0;
    bus.mdu_valid = 1'b0;
    bus.mdu_waddr = 5'd0;
    bus.mdu_wdata = 32'd0;
  endtask

  task automatic drive_ex(input logic [4:0] a, input logic [31:0] d);
    bus.ex_wen   = 1'b1;
    bus.ex_waddr = a;
    bus.ex_wdata = d;
  endtask

  task automatic drive_lsu(input logic [4:0] a, input logic [31:0] d);
    bus.lsu_valid = 1'b1;
    bus.lsu_waddr = a;
    bus.lsu_wdata = d;
  endtask

  task automatic drive_mdu(input logic [4:0] a, input logic [31:0] d);
    bus.mdu_valid = 1'b1;
    bus.mdu_waddr = a;
    bus.mdu_wdata = d;
  endtask

  initial begin
    checks = 0;
    errors = 0;
    idle();
    rst = 1'b1;

    // ---- Reset ----
    tick();
    tick();
    chk("rst_wen",       32'(bus.wen),       32'd0);
    chk("rst_waddr",     32'(bus.rd_waddr),  32'd0);
    chk("rst_wdata",     bus.rd_wdata,       32'd0);
    chk("rst_cnt",       32'(bus.fifo_cnt),  32'd0);
    chk("rst_pend",      bus.pend_mask,      32'd0);
    chk("rst_lsu_ready", 32'(bus.lsu_ready), 32'd0);
    chk("rst_mdu_ready", 32'(bus.mdu_ready), 32'd0);
    rst = 1'b0;
    tick();

    // ---- EX only ----
    drive_ex(5'd5, 32'h0000_1234);
    tick();
    idle();
    chk("ex_wen",   32'(bus.wen),      32'd1);
    chk("ex_waddr", 32'(bus.rd_waddr), 32'd5);
    chk("ex_wdata", bus.rd_wdata,      32'h0000_1234);
    chk("ex_cnt",   32'(bus.fifo_cnt), 32'd0);
    tick();
    chk("ex_wen_off", 32'(bus.wen), 32'd0);

    // ---- Deferred load ----
    drive_ex(5'd3, 32'h0000_0033);
    drive_lsu(5'd7, 32'h0000_DEAD);
    #1;
    chk("def_lsu_ready", 32'(bus.lsu_ready), 32'd1);
    tick();
    idle();
    chk("def_c1_wen",   32'(bus.wen),      32'd1);
    chk("def_c1_waddr", 32'(bus.rd_waddr), 32'd3);
    chk("def_c1_pend",  bus.pend_mask,     32'h0000_0080);
    chk("def_c1_cnt",   32'(bus.fifo_cnt), 32'd1);
    tick();
    chk("def_c2_wen",   32'(bus.wen),      32'd1);
    chk("def_c2_waddr", 32'(bus.rd_waddr), 32'd7);
    chk("def_c2_wdata", bus.rd_wdata,      32'h0000_DEAD);
    chk("def_c2_pend",  bus.pend_mask,     32'd0);
    chk("def_c2_cnt",   32'(bus.fifo_cnt), 32'd0);

    // ---- Fill / full / drain ----
    for (int k = 0; k < 4; k++) begin
      drive_ex(5'd1, 32'(k));
      drive_lsu(5'(10 + k), 32'(32'hA0 + k));
      #1;
      chk("fill_lsu_ready", 32'(bus.lsu_ready), 32'd1);
      tick();
    end
    drive_ex(5'd1, 32'h0000_0055);
    drive_lsu(5'd14, 32'h0000_00EE);
    drive_mdu(5'd15, 32'h0000_00FF);
    #1;
    chk("full_cnt",       32'(bus.fifo_cnt),  32'd4);
    chk("full_lsu_ready", 32'(bus.lsu_ready), 32'd0);
    chk("full_mdu_ready", 32'(bus.mdu_ready), 32'd0);
    chk("full_pend",      bus.pend_mask,      32'h0000_3C00);
    tick();
    chk("full_hold_cnt",  32'(bus.fifo_cnt),  32'd4);
    idle();
    #1;
    chk("drain_lsu_ready", 32'(bus.lsu_ready), 32'd1);
    for (int k = 0; k < 4; k++) begin
      tick();
      chk("drain_wen",   32'(bus.wen),      32'd1);
      chk("drain_waddr", 32'(bus.rd_waddr), 32'(10 + k));
      chk("drain_wdata", bus.rd_wdata,      32'(32'hA0 + k));
      chk("drain_cnt",   32'(bus.fifo_cnt), 32'(3 - k));
    end
    tick();
    chk("drain_done_wen", 32'(bus.wen), 32'd0);

    // ---- LSU + MDU simultaneous, EX idle ----
    drive_lsu(5'd20, 32'h0000_2020);
    drive_mdu(5'd21, 32'h0000_2121);
    #1;
    chk("pri_lsu_ready", 32'(bus.lsu_ready), 32'd1);
    chk("pri_mdu_ready", 32'(bus.mdu_ready), 32'd0);
    tick();
    bus.lsu_valid = 1'b0;
    #1;
    chk("pri_mdu_ready2", 32'(bus.mdu_ready), 32'd1);
    chk("pri_cnt",        32'(bus.fifo_cnt),  32'd1);
    tick();
    idle();
    chk("pri_w1_wen",   32'(bus.wen),      32'd1);
    chk("pri_w1_waddr", 32'(bus.rd_waddr), 32'd20);
    chk("pri_w1_wdata", bus.rd_wdata,      32'h0000_2020);
    tick();
    chk("pri_w2_wen",   32'(bus.wen),      32'd1);
    chk("pri_w2_waddr", 32'(bus.rd_waddr), 32'd21);
    chk("pri_w2_wdata", bus.rd_wdata,      32'h0000_2121);
    tick();
    chk("pri_done_wen", 32'(bus.wen), 32'd0);

    // ---- x0 load result ----
    drive_lsu(5'd0, 32'h0000_0BAD);
    #1;
    chk("x0_lsu_ready", 32'(bus.lsu_ready), 32'd1);
    tick();
    idle();
    chk("x0_cnt", 32'(bus.fifo_cnt), 32'd0);
    chk("x0_wen", 32'(bus.wen),      32'd0);
    tick();
    chk("x0_wen2", 32'(bus.wen), 32'd0);

    // ---- Reset mid-drain ----
    drive_ex(5'd1, 32'h0000_0001);
    drive_lsu(5'd2, 32'h0000_0002);
    tick();
    drive_lsu(5'd4, 32'h0000_0004);
    tick();
    drive_lsu(5'd6, 32'h0000_0006);
    tick();
    idle();
    chk("rmd_cnt",  32'(bus.fifo_cnt), 32'd3);
    chk("rmd_pend", bus.pend_mask,     32'h0000_0054);
    rst = 1'b1;
    tick();
    chk("rmd_wen",  32'(bus.wen),      32'd0);
    chk("rmd_cnt0", 32'(bus.fifo_cnt), 32'd0);
    chk("rmd_pend0", bus.pend_mask,    32'd0);
    rst = 1'b0;
    tick();
    chk("rmd_wen_after", 32'(bus.wen), 32'd0);

`ifdef WB_KILL_EN
    // ---- Kill a queued entry ----
    drive_ex(5'd1, 32'h0000_0011);
    drive_lsu(5'd9, 32'h000D_EAD9);
    tick();
    idle();
    chk("kill_cnt",  32'(bus.fifo_cnt), 32'd1);
    chk("kill_pend", bus.pend_mask,     32'h0000_0200);
    drive_ex(5'd9, 32'h0000_0001);
    tick();
    idle();
    chk("kill_ex_wen",   32'(bus.wen),      32'd1);
    chk("kill_ex_waddr", 32'(bus.rd_waddr), 32'd9);
    chk("kill_ex_wdata", bus.rd_wdata,      32'h0000_0001);
    chk("kill_pend0",    bus.pend_mask,     32'd0);
    chk("kill_cnt1",     32'(bus.fifo_cnt), 32'd1);
    tick();
    chk("kill_pop_wen", 32'(bus.wen),      32'd0);
    chk("kill_pop_cnt", 32'(bus.fifo_cnt), 32'd0);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
